ex_mem_skid_stage: RTL
======================

Name: ex_mem_skid_stage

Overview:
- EX→MEM boundary register for the RV32 datapath.
- Captures ALU_Result/Zero plus destination and memory-control fields from the execute stage.
- Resolves the branch-taken condition from Zero.
- Presents a registered, flow-controlled result to the memory stage through a 2-entry skid buffer, so MEM back-pressure never creates a combinational ready path into EX.

Parameters:
DATA_WIDTH, 32, width of ALU result and store data
REG_ADDR_WIDTH, 5, destination register index width
STALL_CNT_WIDTH, 16, width of saturating back-pressure counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset
valid_i  input  1  EX presents a valid instruction
ready_o  output  1  stage can accept this cycle
ALU_Result_i  input  DATA_WIDTH  ALU result
Zero_i  input  1  ALU zero flag
Store_Data_i  input  DATA_WIDTH  rs2 data for stores
Rd_i  input  REG_ADDR_WIDTH  destination register
Reg_Write_i  input  1  write-back enable
Mem_Read_i  input  1  load
Mem_Write_i  input  1  store
Branch_i  input  1  conditional branch
Branch_Ne_i  input  1  1=BNE, 0=BEQ
Flush_i  input  1  discard all held and incoming entries
valid_o  output  1  MEM-side entry valid
ready_i  input  1  MEM stage accepts
ALU_Result_o  output  DATA_WIDTH  held result (memory address / write-back data)
Store_Data_o  output  DATA_WIDTH  held store data
Rd_o  output  REG_ADDR_WIDTH  held destination
Reg_Write_o, Mem_Read_o, Mem_Write_o  output  1 each  held controls
Branch_Taken_o  output  1  registered branch decision
Stall_Count_o  output  STALL_CNT_WIDTH  cycles with valid_o=1, ready_i=0

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to EMPTY; both entries are cleared; Stall_Count_o=0.
  - valid_o=0 and all data and control outputs are 0.
  - Inputs are ignored while reset=0.
- Handshake signals: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- ready_o = (state != FULL). It is a pure function of registered state, with no path from ready_i.
- Capture computes taken = Branch_i & (Zero_i ^ Branch_Ne_i) and stores it with the entry. Fields are stored verbatim; there is no width conversion.
- State machine (occupancy EMPTY / ONE / FULL; main reg drives the outputs, skid reg holds overflow):
  - EMPTY: in_fire → load main, go to ONE.
  - ONE, in_fire & out_fire → reload main, stay in ONE.
  - ONE, in_fire & ~out_fire → load skid, go to FULL.
  - ONE, ~in_fire & out_fire → EMPTY.
  - FULL: out_fire → move skid to main, go to ONE. in_fire is impossible because ready_o=0.
- valid_o = (state != EMPTY).
- Latency: an input accepted at edge N appears on the outputs after edge N when the stage was EMPTY or was draining. Data order is strictly FIFO.
- Outputs are stable while valid_o=1 and ready_i=0.
- Flush_i=1 at an edge:
  - State goes to EMPTY and valid_o=0 next cycle.
  - A same-cycle in_fire is dropped; flush has priority.
  - Stall_Count_o is not cleared.
- Stall_Count_o increments each edge with valid_o=1 and ready_i=0. It saturates at all-ones and does not wrap.
- Register indices are stored as given. An entry with Rd=0 is held unchanged; x0 write suppression belongs to the register file.
- When Mem_Read and Mem_Write are both set, the fields pass through unmodified; there is no arbitration here.

Decomposition:
- The shared package holds:
  - the occupancy encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the packed EX/MEM entry bundle layout (result, store data, rd, reg_write, mem_read, mem_write, taken) and its total width.
- One sub-module is natural: ex_mem_entry_reg, a resettable, enable-loaded register of the packed bundle, instantiated twice (main, skid).

Test Plan:
- Reset: hold reset=0 for 3 cycles with valid_i=1 → valid_o=0, ready_o=1, all outputs 0, Stall_Count_o=0.
- Streaming: ready_i=1, inputs ALU_Result 0x10, 0x20, 0x30 on consecutive cycles → valid_o=1 and outputs 0x10, 0x20, 0x30 on consecutive cycles one cycle later; ready_o stays 1.
- Back-pressure: ready_i=0, send 0xAAAA then 0xBBBB.
  - After the second edge: ready_o=0, ALU_Result_o=0xAAAA, and Stall_Count_o increments each cycle.
  - Raise ready_i → 0xAAAA then 0xBBBB delivered; ready_o returns to 1.
- Branch: Branch_i=1, Branch_Ne_i=0, Zero_i=1 → Branch_Taken_o=1. Zero_i=0 → 0. Branch_Ne_i=1, Zero_i=0 → 1.
- Flush: FULL state with a simultaneous valid_i=1 carrying 0xDEAD and Flush_i=1 → next cycle valid_o=0, state EMPTY; 0xDEAD never appears.
- Saturation: STALL_CNT_WIDTH=4, ready_i=0 for 20 cycles with valid_o=1 → Stall_Count_o stops at 15.

Source files
------------

// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared definitions for the EX/MEM skid stage: occupancy encoding and
// the bit layout of one packed EX/MEM entry.
package ex_mem_skid_stage_pkg;

  // Occupancy of the two-entry skid buffer.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } occ_e;

  // Entry layout, MSB to LSB:
  //   {result[DW], store_data[DW], rd[RW], reg_write, mem_read, mem_write, taken}
  localparam int TAKEN_BIT     = 0;
  localparam int MEM_WRITE_BIT = 1;
  localparam int MEM_READ_BIT  = 2;
  localparam int REG_WRITE_BIT = 3;
  localparam int RD_LSB        = 4;

  function automatic int store_lsb(int rw);
    return RD_LSB + rw;
  endfunction

  function automatic int result_lsb(int dw, int rw);
    return store_lsb(rw) + dw;
  endfunction

  function automatic int entry_width(int dw, int rw);
    return result_lsb(dw, rw) + dw;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_entry_reg.sv
// One EX/MEM entry register: synchronous clear, loads only when enabled.
module ex_mem_entry_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the entry; clear on reset, capture on load.
  always_ff @(posedge clk) begin
    // NOTE: the whole entry is cleared on reset so the held outputs read 0,
    // not leftover data; it is only a handful of flops, not a memory array.
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM boundary register with a 2-entry skid buffer. ready_o depends only
// on registered occupancy, so MEM back-pressure never reaches EX combinationally.
module ex_mem_skid_stage
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DATA_WIDTH-1:0]      ALU_Result_i,
  input  logic                       Zero_i,
  input  logic [DATA_WIDTH-1:0]      Store_Data_i,
  input  logic [REG_ADDR_WIDTH-1:0]  Rd_i,
  input  logic                       Reg_Write_i,
  input  logic                       Mem_Read_i,
  input  logic                       Mem_Write_i,
  input  logic                       Branch_i,
  input  logic                       Branch_Ne_i,
  input  logic                       Flush_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DATA_WIDTH-1:0]      ALU_Result_o,
  output logic [DATA_WIDTH-1:0]      Store_Data_o,
  output logic [REG_ADDR_WIDTH-1:0]  Rd_o,
  output logic                       Reg_Write_o,
  output logic                       Mem_Read_o,
  output logic                       Mem_Write_o,
  output logic                       Branch_Taken_o,
  output logic [STALL_CNT_WIDTH-1:0] Stall_Count_o
);

  localparam int EW      = entry_width(DATA_WIDTH, REG_ADDR_WIDTH);
  localparam int SD_LSB  = store_lsb(REG_ADDR_WIDTH);
  localparam int RES_LSB = result_lsb(DATA_WIDTH, REG_ADDR_WIDTH);

  occ_e            state_q;
  occ_e            state_d;
  logic            in_fire;
  logic            out_fire;
  logic            taken;
  logic            load_main;
  logic            load_skid;
  logic            main_from_skid;
  logic [EW-1:0]   in_entry;
  logic [EW-1:0]   main_d;
  logic [EW-1:0]   main_q;
  logic [EW-1:0]   skid_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  assign ready_o  = (state_q != S_FULL);
  assign valid_o  = (state_q != S_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Branch is resolved at capture: BEQ takes on Zero, BNE on ~Zero.
  assign taken    = Branch_i & (Zero_i ^ Branch_Ne_i);
  assign in_entry = {ALU_Result_i, Store_Data_i, Rd_i,
                     Reg_Write_i, Mem_Read_i, Mem_Write_i, taken};
  assign main_d   = main_from_skid ? skid_q : in_entry;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and entry load enables; flush overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = S_FULL;
        end else if (out_fire) begin
          state_d   = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (Flush_i) begin
      state_d   = S_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  ex_mem_entry_reg #(.WIDTH(EW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  ex_mem_entry_reg #(.WIDTH(EW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Saturating count of cycles the MEM side is holding off a valid entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (valid_o && !ready_i && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign ALU_Result_o   = main_q[RES_LSB +: DATA_WIDTH];
  assign Store_Data_o   = main_q[SD_LSB +: DATA_WIDTH];
  assign Rd_o           = main_q[RD_LSB +: REG_ADDR_WIDTH];
  assign Reg_Write_o    = main_q[REG_WRITE_BIT];
  assign Mem_Read_o     = main_q[MEM_READ_BIT];
  assign Mem_Write_o    = main_q[MEM_WRITE_BIT];
  assign Branch_Taken_o = main_q[TAKEN_BIT];
  assign Stall_Count_o  = stall_q;

endmodule
